// File: rtl/mem_access_controller.sv
// mem_access_controller: single-outstanding load/store controller with a registered memory-side interface
// Ports: clk/reset (async, active-high); req_valid_i/req_ready_o/req_we_i/req_addr_i/req_wdata_i request side;
//        rsp_valid_o/rsp_ready_i/rsp_rdata_o/rsp_error_o response side;
//        mem_address_o/mem_write_enable_o/mem_write_data_o/mem_read_data_i memory side.
// Macro MISALIGN_CHECK_EN: fault misaligned requests instead of silently word-aligning them.
module mem_access_controller #(
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_error_o,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    output logic                  mem_write_enable_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    input  logic [DATA_WIDTH-1:0] mem_read_data_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    state_t r_state, w_next;
    logic [3:0] r_cnt;
    logic r_we, r_mem_we, r_err, w_accept, w_misalign;
    logic [DATA_WIDTH-1:0] r_addr, r_wdata, r_rdata;

    assign w_accept = req_valid_i && r_state == IDLE;
`ifdef MISALIGN_CHECK_EN
    assign w_misalign = req_addr_i[1:0] != 2'b00;
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (w_misalign ? RESP : ACCESS) : IDLE;
            ACCESS:  w_next = (r_we || WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    w_next = r_cnt == 4'd1 ? RESP : WAIT;
            RESP:    w_next = rsp_ready_i ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Store responses carry zero data, so rdata is cleared at accept and only loads overwrite it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_mem_we <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_err   <= w_misalign;
                    r_rdata <= '0;
                    if (!w_misalign) begin
                        r_addr   <= req_addr_i & {{(DATA_WIDTH-2){1'b1}}, 2'b00};
                        r_wdata  <= req_wdata_i;
                        r_we     <= req_we_i;
                        r_mem_we <= req_we_i;
                    end
                end
                ACCESS: if (!r_we) begin
                    if (WAIT_CYCLES == 0) r_rdata <= mem_read_data_i;
                    else                  r_cnt   <= 4'(WAIT_CYCLES);
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_rdata <= mem_read_data_i;
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o        = r_state == IDLE;
    assign rsp_valid_o        = r_state == RESP;
    assign rsp_rdata_o        = r_rdata;
    assign rsp_error_o        = r_err;
    assign mem_address_o      = r_addr;
    assign mem_write_enable_o = r_mem_we;
    assign mem_write_data_o   = r_wdata;
endmodule

// File: tb/tb_mem_access_controller.sv
// tb_mem_access_controller: three controllers (WAIT_CYCLES 0/1/3) share one request stream; a scoreboard checks each response
module tb_mem_access_controller;
    function automatic int wc_of(int g);
        return g == 0 ? 0 : g == 1 ? 1 : 3;
    endfunction

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        chk_addr;
        int          acc;
    } exp_t;

    logic clk = 1'b0, reset = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0] req_ready, rsp_valid, rsp_err, mwe;
    logic [31:0] rsp_rdata [3];
    logic [31:0] maddr [3];
    logic [31:0] mwdata [3];
    logic [31:0] mrdata [3];

    exp_t exp_q[$];
    int rd_ptr [3];
    int we_cnt [3];
    logic [31:0] we_addr [3];
    logic [31:0] held_rdata [3];
    logic held_err [3];
    logic [2:0] seen = '0;
    int edge_cnt = 0, n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    for (genvar g = 0; g < 3; g++) begin : gd
        logic [31:0] mem [64];
        logic [31:0] rd_q;
        always @(posedge clk) begin
            if (mwe[g]) mem[maddr[g][7:2]] <= mwdata[g];
            rd_q <= mem[maddr[g][7:2]];
        end
        // WAIT_CYCLES=0 needs same-cycle read data; the others see a 1-cycle-latency memory
        assign mrdata[g] = (g == 0) ? mem[maddr[g][7:2]] : rd_q;
        mem_access_controller #(.DATA_WIDTH(32), .WAIT_CYCLES(wc_of(g))) dut (
            .clk(clk), .reset(reset),
            .req_valid_i(req_valid), .req_ready_o(req_ready[g]), .req_we_i(req_we),
            .req_addr_i(req_addr), .req_wdata_i(req_wdata),
            .rsp_valid_o(rsp_valid[g]), .rsp_ready_i(rsp_ready),
            .rsp_rdata_o(rsp_rdata[g]), .rsp_error_o(rsp_err[g]),
            .mem_address_o(maddr[g]), .mem_write_enable_o(mwe[g]),
            .mem_write_data_o(mwdata[g]), .mem_read_data_i(mrdata[g])
        );
    end

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d (WAIT_CYCLES=%0d): got %h expected %h at %0t", name, g, wc_of(g), act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (mwe[g]) begin
                we_cnt[g]++;
                we_addr[g] = maddr[g];
            end
            if (!rsp_valid[g]) seen[g] = 1'b0;
            else if (seen[g]) begin
                chk("hold_rdata", g, rsp_rdata[g], held_rdata[g]);
                chk("hold_error", g, 32'(rsp_err[g]), 32'(held_err[g]));
            end else if (rd_ptr[g] >= exp_q.size()) begin
                chk("spurious_rsp", g, 32'(rsp_valid[g]), 32'd0);
                seen[g] = 1'b1;
            end else begin
                exp_t e;
                e = exp_q[rd_ptr[g]];
                rd_ptr[g]++;
                seen[g] = 1'b1;
                chk("latency", g, 32'(edge_cnt + 1 - e.acc), 32'(e.err ? 1 : e.we ? 2 : wc_of(g) + 2));
                chk("rdata", g, rsp_rdata[g], e.rdata);
                chk("error", g, 32'(rsp_err[g]), 32'(e.err));
                chk("strobe_count", g, 32'(we_cnt[g]), (e.we && !e.err) ? 32'd1 : 32'd0);
                if (e.chk_addr) chk("mem_addr", g, maddr[g], e.addr);
                if (e.we && !e.err) chk("strobe_addr", g, we_addr[g], e.addr);
                we_cnt[g] = 0;
                held_rdata[g] = e.rdata;
                held_err[g] = e.err;
            end
        end
    end

    function automatic bit all_idle();
        for (int g = 0; g < 3; g++)
            if (!req_ready[g] || rd_ptr[g] != exp_q.size()) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!all_idle() && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 0, 32'(n), 32'd0);
    endtask

    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] erdata, input bit eerr, input bit chka, input logic [31:0] eaddr);
        exp_t e;
        wait_idle();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        e.we = we; e.err = eerr; e.rdata = erdata; e.addr = eaddr; e.chk_addr = chka; e.acc = edge_cnt + 1;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk({tag, "_rsp_valid"}, g, 32'(rsp_valid[g]), 32'd0);
            chk({tag, "_mem_we"}, g, 32'(mwe[g]), 32'd0);
            chk({tag, "_rsp_err"}, g, 32'(rsp_err[g]), 32'd0);
            chk({tag, "_rsp_rdata"}, g, rsp_rdata[g], 32'd0);
            chk({tag, "_mem_addr"}, g, maddr[g], 32'd0);
            chk({tag, "_mem_wdata"}, g, mwdata[g], 32'd0);
            chk({tag, "_req_ready"}, g, 32'(req_ready[g]), 32'd1);
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        issue(1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, 32'h10);
        issue(0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, 32'h10);
        issue(1, 32'h20, 32'h11111111, 32'h0, 0, 1, 32'h20);
        issue(1, 32'h24, 32'hCAFEF00D, 32'h0, 0, 1, 32'h24);
        issue(0, 32'h24, 32'h0, 32'hCAFEF00D, 0, 1, 32'h24);

        // back-pressure with a competing store held on the request port
        wait_idle();
        rsp_ready = 1'b0;
        issue(0, 32'h20, 32'h0, 32'h11111111, 0, 1, 32'h20);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hBAD0BAD0;
        repeat (10) begin
            for (int g = 0; g < 3; g++) chk("bp_req_ready", g, 32'(req_ready[g]), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
        issue(0, 32'h20, 32'h0, 32'h11111111, 0, 1, 32'h20);

`ifdef MISALIGN_CHECK_EN
        issue(0, 32'h13, 32'h0, 32'h0, 1, 0, 32'h0);
        issue(1, 32'h22, 32'h55555555, 32'h0, 1, 0, 32'h0);
        issue(0, 32'h20, 32'h0, 32'h11111111, 0, 1, 32'h20);
`else
        issue(0, 32'h13, 32'h0, 32'hDEADBEEF, 0, 1, 32'h10);
`endif

        // reset while the WAIT_CYCLES=3 controller is still in WAIT
        issue(0, 32'h24, 32'h0, 32'hCAFEF00D, 0, 1, 32'h24);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        for (int g = 0; g < 3; g++) rd_ptr[g] = exp_q.size();
        @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                chk("post_reset_valid", g, 32'(rsp_valid[g]), 32'd0);
                chk("post_reset_we", g, 32'(mwe[g]), 32'd0);
            end
        end
        issue(0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, 32'h10);
        wait_idle();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
